mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: LOAD / STORE / byte COPY sequencer driving a data memory
// with a combinational read port. Every output is a flop.
module mem_access_unit #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LD_RD, ST_WR, CP_RD, CP_WR, RESP} state_t;

  localparam logic [1:0]        OP_LOAD  = 2'b00;
  localparam logic [1:0]        OP_STORE = 2'b01;
  localparam logic [1:0]        OP_COPY  = 2'b10;
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, hold_q, hold_d;
  logic                req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d, mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  // Outputs are computed for the state being entered, so they are valid
  // throughout the cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          src_d   = req_addr;
          dst_d   = req_dst;
          len_d   = req_len;
          wdata_d = req_wdata;
          cnt_d   = '0;
          case (req_op)
            OP_LOAD: begin
              state_d    = LD_RD;
              mem_rd_d   = 1'b1;
              mem_addr_d = req_addr;
            end
            OP_STORE: begin
              state_d     = ST_WR;
              mem_wr_d    = 1'b1;
              mem_addr_d  = req_addr;
              mem_wdata_d = req_wdata;
            end
            OP_COPY: begin
              if (req_len == '0) begin
                state_d     = RESP;
                resp_data_d = '0;
                resp_err_d  = 1'b0;
              end else begin
                state_d    = CP_RD;
                mem_rd_d   = 1'b1;
                mem_addr_d = req_addr;
              end
            end
            default: begin
              state_d     = RESP;
              resp_data_d = '0;
              resp_err_d  = 1'b1;
            end
          endcase
        end
      end
      LD_RD: begin
        state_d     = RESP;
        resp_data_d = mem_rdata;
        resp_err_d  = 1'b0;
      end
      ST_WR: begin
        state_d     = RESP;
        resp_data_d = wdata_q;
        resp_err_d  = 1'b0;
      end
      CP_RD: begin
        state_d     = CP_WR;
        hold_d      = mem_rdata;
        mem_wr_d    = 1'b1;
        mem_addr_d  = dst_q + cnt_q;
        mem_wdata_d = mem_rdata;
      end
      CP_WR: begin
        if (cnt_q == len_q - ONE) begin
          state_d     = RESP;
          resp_data_d = hold_q;
          resp_err_d  = 1'b0;
        end else begin
          state_d    = CP_RD;
          cnt_d      = cnt_q + ONE;
          mem_rd_d   = 1'b1;
          mem_addr_d = src_q + cnt_q + ONE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      hold_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// transactions compared against a transaction-level memory model.
module tb_mem_access_unit;
  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0, req_dst = '0, req_len = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory driven by the DUT, plus a bench-side fill port.
  logic [DW-1:0] mem [128];
  logic [DW-1:0] ref_mem [128];
  logic          tb_wr = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [DW-1:0] tb_wdat = '0;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    else if (tb_wr) mem[tb_waddr] <= tb_wdat;
  end
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int failures = 0;
  logic [15:0] trace [$];
  logic [DW-1:0] prev_data = '0;
  logic          prev_err = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: record every memory access, check exclusivity and idle zeros.
  always @(negedge clk) begin
    check_val("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
    if (mem_rd || mem_wr)
      trace.push_back({mem_wr, mem_addr, (mem_wr ? mem_wdata : mem_rdata)});
    else
      check_val("idle_addr_wdata", {17'd0, mem_addr, mem_wdata}, 32'd0);
  end

  function automatic int mem_diffs();
    int n = 0;
    for (int a = 0; a < 128; a++) if (mem[a] !== ref_mem[a]) n++;
    return n;
  endfunction

  task automatic scramble();
    req_op    = 2'($urandom);
    req_addr  = AW'($urandom);
    req_dst   = AW'($urandom);
    req_len   = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  // Issue one request and wait for its response; lat counts edges from
  // acceptance to the edge that ends the resp_valid cycle.
  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] d,
                        input logic [AW-1:0] l, input logic [DW-1:0] w, input bit hold,
                        output int lat);
    int waited = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_dst = d; req_len = l; req_wdata = w;
    while (!req_ready && waited < 50) begin @(posedge clk); #1; waited++; end
    if (!req_ready) check_val("ready_timeout", 32'd0, 32'd1);
    trace.delete();
    @(posedge clk); #1;
    scramble();
    req_valid = hold;
    lat = 1;
    while (!resp_valid && lat < 400) begin
      check_val("busy_not_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    if (resp_valid) check_val("resp_not_ready", {31'd0, req_ready}, 32'd0);
  endtask

  // Reference model at transaction level, then compare everything observable.
  task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] w, input bit hold);
    logic [15:0]   exp_tr [$];
    logic [DW-1:0] exp_data = '0;
    logic [AW-1:0] s, t;
    logic [DW-1:0] b;
    int            exp_lat, lat;
    check_val("resp_data_hold", {24'd0, resp_data}, {24'd0, prev_data});
    check_val("resp_err_hold", {31'd0, resp_err}, {31'd0, prev_err});
    case (op)
      2'd0: begin exp_lat = 2; exp_data = ref_mem[a]; exp_tr.push_back({1'b0, a, ref_mem[a]}); end
      2'd1: begin exp_lat = 2; exp_data = w; ref_mem[a] = w; exp_tr.push_back({1'b1, a, w}); end
      2'd2: begin
        exp_lat = (l == 0) ? 1 : 2 * int'(l) + 1;
        for (int i = 0; i < int'(l); i++) begin
          s = a + AW'(i); t = d + AW'(i); b = ref_mem[s];
          exp_tr.push_back({1'b0, s, b});
          exp_tr.push_back({1'b1, t, b});
          ref_mem[t] = b;
          exp_data = b;
        end
      end
      default: exp_lat = 1;
    endcase
    do_req(op, a, d, l, w, hold, lat);
    check_val("latency", lat, exp_lat);
    check_val("resp_valid", {31'd0, resp_valid}, 32'd1);
    check_val("resp_data", {24'd0, resp_data}, {24'd0, exp_data});
    check_val("resp_err", {31'd0, resp_err}, {31'd0, (op == 2'd3)});
    @(posedge clk); #1;
    check_val("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    check_val("ready_after_resp", {31'd0, req_ready}, 32'd1);
    check_val("strobe_count", trace.size(), exp_tr.size());
    for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
      check_val("strobe_seq", {16'd0, trace[i]}, {16'd0, exp_tr[i]});
    check_val("mem_image_diffs", mem_diffs(), 32'd0);
    prev_data = exp_data;
    prev_err  = (op == 2'd3);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] v;
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp", {22'd0, resp_valid, resp_err, resp_data}, 32'd0);
    check_val("rst_mem_if", {15'd0, mem_rd, mem_wr, mem_addr, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill memory with random bytes through the bench port
    for (int a = 0; a < 128; a++) begin
      v = DW'($urandom);
      tb_wr = 1'b1; tb_waddr = AW'(a); tb_wdat = v; ref_mem[a] = v;
      @(posedge clk); #1;
    end
    tb_wr = 1'b0;
    check_val("fill_image", mem_diffs(), 32'd0);

    // STORE then LOAD
    run_txn(2'd1, 7'h10, 7'h00, 7'h00, 8'hA5, 1'b0);
    check_val("store_mem_0x10", {24'd0, mem[7'h10]}, 32'hA5);
    run_txn(2'd0, 7'h10, 7'h00, 7'h00, 8'h00, 1'b0);
    check_val("load_0x10", {24'd0, resp_data}, 32'hA5);

    // Preload and COPY of three bytes
    run_txn(2'd1, 7'h20, 7'h00, 7'h00, 8'h11, 1'b0);
    run_txn(2'd1, 7'h21, 7'h00, 7'h00, 8'h22, 1'b0);
    run_txn(2'd1, 7'h22, 7'h00, 7'h00, 8'h33, 1'b0);
    run_txn(2'd2, 7'h20, 7'h40, 7'd3, 8'h00, 1'b0);
    check_val("copy_dst", {8'd0, mem[7'h40], mem[7'h41], mem[7'h42]}, 32'h112233);
    check_val("copy_last", {24'd0, resp_data}, 32'h33);

    // Wrap-around overlapping copy, reserved op, zero-length copy
    run_txn(2'd2, 7'h7F, 7'h7E, 7'd2, 8'h00, 1'b0);
    run_txn(2'd3, 7'h05, 7'h06, 7'd9, 8'hFF, 1'b0);
    run_txn(2'd2, 7'h30, 7'h50, 7'd0, 8'h00, 1'b0);

    // Requests held valid across busy periods, back to back
    run_txn(2'd0, 7'h41, 7'h00, 7'h00, 8'h00, 1'b1);
    run_txn(2'd2, 7'h10, 7'h12, 7'd5, 8'h00, 1'b1);
    run_txn(2'd1, 7'h7F, 7'h00, 7'h00, 8'h5A, 1'b0);
    run_txn(2'd2, 7'h00, 7'h01, 7'd127, 8'h00, 1'b0);

    // Random traffic
    for (int n = 0; n < 150; n++)
      run_txn(2'($urandom), AW'($urandom), AW'($urandom), AW'($urandom_range(0, 12)),
              DW'($urandom), 1'($urandom));

    // Reset during byte 1 of a four-byte copy
    req_valid = 1'b1; req_op = 2'd2; req_addr = 7'h58; req_dst = 7'h68; req_len = 7'd4;
    for (int i = 0; i < 50 && !req_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;                  // accepted: CP_RD byte 0
    req_valid = 1'b0;
    @(posedge clk); #1;                  // CP_WR byte 0
    @(posedge clk); #1;                  // CP_RD byte 1
    ref_mem[7'h68] = ref_mem[7'h58];
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    check_val("abort_ready", {31'd0, req_ready}, 32'd1);
    check_val("abort_resp", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check_val("abort_ready_after", {31'd0, req_ready}, 32'd1);
    check_val("abort_image", mem_diffs(), 32'd0);
    prev_data = '0; prev_err = 1'b0;
    run_txn(2'd0, 7'h68, 7'h00, 7'h00, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
